// File: rtl/proc_control.sv
// proc_control: T0-T3 sequencer for the 16-bit simple processor (mv, mvi, add, sub).
// Optional feature: define PROC_CTRL_MVNZ_EN to add opcode 100 (mvnz Rx,Ry).
`default_nettype none

module proc_control #(
  parameter int DIN_W = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Run,
  input  logic [DIN_W-1:0] DIN,
  input  logic             Gnz,
  output logic [0:7]       Rout,
  output logic             Gout,
  output logic             DINout,
  output logic [0:7]       Rin,
  output logic             Ain,
  output logic             Gin,
  output logic             AddSub,
  output logic             IRin,
  output logic             Done,
  output logic [1:0]       Tstep
);

  localparam logic [1:0] T0 = 2'd0;
  localparam logic [1:0] T1 = 2'd1;
  localparam logic [1:0] T2 = 2'd2;
  localparam logic [1:0] T3 = 2'd3;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_MVNZ = 3'b100;

  logic [1:0] step_q, step_d;
  logic [8:0] ir_q, ir_d;
  logic [2:0] op, rx, ry;

  // Upper DIN bits carry only immediates for the datapath; Gnz is idle without mvnz.
  logic unused_inputs;
  assign unused_inputs = ^{DIN, Gnz};

  assign op    = ir_q[8:6];
  assign rx    = ir_q[5:3];
  assign ry    = ir_q[2:0];
  assign Tstep = step_q;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      step_q <= T0;
      ir_q   <= 9'd0;
    end else begin
      step_q <= step_d;
      ir_q   <= ir_d;
    end
  end

  always_comb begin
    Rout   = 8'd0;
    Rin    = 8'd0;
    Gout   = 1'b0;
    DINout = 1'b0;
    Ain    = 1'b0;
    Gin    = 1'b0;
    AddSub = 1'b0;
    IRin   = 1'b0;
    Done   = 1'b0;
    step_d = step_q;
    ir_d   = ir_q;

    case (step_q)
      T0: begin
        if (Run) begin
          IRin   = 1'b1;
          ir_d   = DIN[8:0];
          step_d = T1;
        end
      end
      T1: begin
        case (op)
          OP_MV: begin
            Rout[ry] = 1'b1;
            Rin[rx]  = 1'b1;
            Done     = 1'b1;
          end
          OP_MVI: begin
            DINout  = 1'b1;
            Rin[rx] = 1'b1;
            Done    = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            Rout[rx] = 1'b1;
            Ain      = 1'b1;
          end
`ifdef PROC_CTRL_MVNZ_EN
          OP_MVNZ: begin
            if (Gnz) begin
              Rout[ry] = 1'b1;
              Rin[rx]  = 1'b1;
            end
            Done = 1'b1;
          end
`endif
          default: Done = 1'b1;
        endcase
        step_d = Done ? T0 : T2;
      end
      T2: begin
        Rout[ry] = 1'b1;
        Gin      = 1'b1;
        AddSub   = (op == OP_SUB);
        step_d   = T3;
      end
      default: begin
        Gout    = 1'b1;
        Rin[rx] = 1'b1;
        Done    = 1'b1;
        step_d  = T0;
      end
    endcase

    // Reset silences every strobe so nothing loads during the reset cycle.
    if (Reset) begin
      Rout   = 8'd0;
      Rin    = 8'd0;
      Gout   = 1'b0;
      DINout = 1'b0;
      Ain    = 1'b0;
      Gin    = 1'b0;
      AddSub = 1'b0;
      IRin   = 1'b0;
      Done   = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_proc_control.sv
// tb_proc_control: scoreboard bench for proc_control (honours PROC_CTRL_MVNZ_EN if defined).
`default_nettype none

module tb_proc_control;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Run   = 1'b0;
  logic [15:0] DIN   = 16'd0;
  logic        Gnz   = 1'b0;
  logic [0:7]  Rout, Rin;
  logic        Gout, DINout, Ain, Gin, AddSub, IRin, Done;
  logic [1:0]  Tstep;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [24:0] sb[$];

  always #5 Clock = ~Clock;

  proc_control #(.DIN_W(16)) dut (
    .Clock(Clock), .Reset(Reset), .Run(Run), .DIN(DIN), .Gnz(Gnz),
    .Rout(Rout), .Gout(Gout), .DINout(DINout), .Rin(Rin), .Ain(Ain),
    .Gin(Gin), .AddSub(AddSub), .IRin(IRin), .Done(Done), .Tstep(Tstep)
  );

  task automatic check(input string tag, input logic [24:0] got, input logic [24:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] oh(input logic [2:0] i);
    oh = 8'b10000000 >> i;
  endfunction

  // Expected-vector layout: {Rout, Gout, DINout, Rin, Ain, Gin, AddSub, IRin, Done, Tstep}
  function automatic logic [24:0] mk(input logic [7:0] ro, input logic go, input logic dio,
                                     input logic [7:0] ri, input logic ai, input logic gi,
                                     input logic as, input logic ir, input logic dn,
                                     input logic [1:0] ts);
    mk = {ro, go, dio, ri, ai, gi, as, ir, dn, ts};
  endfunction

  // Drive one cycle's inputs, queue its expected outputs, compare at the falling edge.
  task automatic cycle(input string tag, input logic rst, input logic run,
                       input logic [15:0] din, input logic gnz, input logic [24:0] exp);
    logic [24:0] e;
    Reset = rst; Run = run; DIN = din; Gnz = gnz;
    sb.push_back(exp);
    @(negedge Clock);
    cyc++;
    e = sb.pop_front();
    check(tag, {Rout, Gout, DINout, Rin, Ain, Gin, AddSub, IRin, Done, Tstep}, e);
    check("bus1hot", 25'($countones({Rout, Gout, DINout}) <= 1), 25'd1);
    @(posedge Clock); #1;
  endtask

  task automatic run_instr(input string tag, input logic [8:0] ir, input logic gnz,
                           input logic [15:0] imm);
    logic [2:0] op, x, y;
    op = ir[8:6]; x = ir[5:3]; y = ir[2:0];
    cycle({tag, "_T0"}, 1'b0, 1'b1, {7'd0, ir}, gnz, mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 2'd0));
    case (op)
      3'b000: cycle({tag, "_T1"}, 0, 1, 16'd0, gnz, mk(oh(y), 0, 0, oh(x), 0, 0, 0, 0, 1, 2'd1));
      3'b001: cycle({tag, "_T1"}, 0, 1, imm, gnz, mk(0, 0, 1, oh(x), 0, 0, 0, 0, 1, 2'd1));
      3'b010, 3'b011: begin
        cycle({tag, "_T1"}, 0, 1, 16'd0, gnz, mk(oh(x), 0, 0, 0, 1, 0, 0, 0, 0, 2'd1));
        cycle({tag, "_T2"}, 0, 1, 16'd0, gnz, mk(oh(y), 0, 0, 0, 0, 1, op[0], 0, 0, 2'd2));
        cycle({tag, "_T3"}, 0, 1, 16'd0, gnz, mk(0, 1, 0, oh(x), 0, 0, 0, 0, 1, 2'd3));
      end
`ifdef PROC_CTRL_MVNZ_EN
      3'b100: begin
        if (gnz) cycle({tag, "_T1"}, 0, 1, 16'd0, gnz, mk(oh(y), 0, 0, oh(x), 0, 0, 0, 0, 1, 2'd1));
        else     cycle({tag, "_T1"}, 0, 1, 16'd0, gnz, mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd1));
      end
`endif
      default: cycle({tag, "_T1"}, 0, 1, 16'd0, gnz, mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd1));
    endcase
  endtask

  localparam logic [24:0] IDLE = 25'd0;

  initial begin
    repeat (2) @(posedge Clock);
    #1;
    cycle("reset", 1'b1, 1'b0, 16'd0, 1'b0, IDLE);
    cycle("idle", 1'b0, 1'b0, 16'h01FF, 1'b0, IDLE);

    run_instr("mv_r2_r5", 9'b000_010_101, 1'b0, 16'd0);
    cycle("after_mv", 0, 0, 16'd0, 0, IDLE);
    run_instr("mvi_r7", 9'b001_111_000, 1'b0, 16'h00AB);
    cycle("after_mvi", 0, 0, 16'd0, 0, IDLE);
    run_instr("sub_r1_r6", 9'b011_001_110, 1'b0, 16'd0);
    cycle("after_sub", 0, 0, 16'd0, 0, IDLE);
    run_instr("mv_r3_r3", 9'b000_011_011, 1'b0, 16'd0);
    run_instr("add_r3_r3", 9'b010_011_011, 1'b0, 16'd0);

    // add aborted by reset in T2: no Done, back to T0
    cycle("abort_T0", 0, 1, 16'h0094, 0, mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 2'd0));
    cycle("abort_T1", 0, 0, 16'd0, 0, mk(oh(3'd2), 0, 0, 0, 1, 0, 0, 0, 0, 2'd1));
    cycle("abort_T2", 1, 0, 16'd0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd2));
    cycle("abort_after", 0, 0, 16'd0, 0, IDLE);
    run_instr("post_abort_mv", 9'b000_100_001, 1'b0, 16'd0);

    // back-to-back with Run held high: Done at cycles 2, 6, 8 after first fetch
    run_instr("b2b_mv", 9'b000_000_111, 1'b0, 16'd0);
    run_instr("b2b_add", 9'b010_101_110, 1'b0, 16'd0);
    run_instr("b2b_mvi", 9'b001_000_000, 1'b0, 16'h1234);
    cycle("after_b2b", 0, 0, 16'd0, 0, IDLE);

    run_instr("op100_gnz0", 9'b100_011_010, 1'b0, 16'd0);
    run_instr("op100_gnz1", 9'b100_011_010, 1'b1, 16'd0);
    run_instr("op111_nop", 9'b111_110_101, 1'b1, 16'd0);
    cycle("final_idle", 0, 0, 16'd0, 0, IDLE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
